// File: rtl/vec_op_dispatch_pkg.sv
// Shared state encoding, operation kinds and the lane-mask helper for the
// vector-operation dispatcher.
package vec_op_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic OP_LEN = 1'b0;
  localparam logic OP_IP  = 1'b1;

  // Upper bound on lanes the helper can describe; callers slice what they need.
  localparam int unsigned LANE_MASK_W = 64;

  function automatic logic [LANE_MASK_W-1:0] lane_mask(input int unsigned dim);
    lane_mask = '0;
    for (int unsigned i = 0; i < LANE_MASK_W; i++) begin
      lane_mask[i] = (i < dim);
    end
  endfunction

endpackage

// File: rtl/vec_op_dispatch_if.sv
// Command/operand channel between the operation source and the dispatcher.
interface vec_op_dispatch_if #(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 4,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
);
  logic                      op_valid;
  logic                      op_ready;
  logic                      op_kind;
  logic [DIM_W-1:0]          op_dim;
  logic [MAX_DIM*DATA_W-1:0] a_in;
  logic [MAX_DIM*DATA_W-1:0] b_in;

  modport master (output op_valid, op_kind, op_dim, a_in, b_in, input op_ready);
  modport slave  (input op_valid, op_kind, op_dim, a_in, b_in, output op_ready);
endinterface

// File: rtl/vec_op_dispatch_lane_mask.sv
// Zeroes every lane of a packed vector bus at or above the given dimension.
module vec_lane_mask
  import vec_op_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 4,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic [DIM_W-1:0]          dim_i,
  input  logic [MAX_DIM*DATA_W-1:0] data_i,
  output logic [MAX_DIM*DATA_W-1:0] data_o
);

  logic [LANE_MASK_W-1:0] mask;

  assign mask = lane_mask(32'(dim_i));

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
    assign data_o[i*DATA_W +: DATA_W] = mask[i] ? data_i[i*DATA_W +: DATA_W] : '0;
  end

  // Mask bits beyond the configured lane count have no consumer.
  if (MAX_DIM < LANE_MASK_W) begin : g_spare
    logic unusedMaskBits;
    assign unusedMaskBits = ^mask[LANE_MASK_W-1:MAX_DIM];
  end

endmodule

// File: rtl/vec_op_dispatch.sv
// Vector-operation front end: latches masked operands, strobes the selected
// arithmetic unit and holds the operands until it finishes or times out.
module vec_op_dispatch
  import vec_op_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 4,
  parameter int DIM_W   = $clog2(MAX_DIM + 1),
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  vec_op_dispatch_if.slave          cmd,
  output logic [MAX_DIM*DATA_W-1:0] a_out,
  output logic [MAX_DIM*DATA_W-1:0] b_out,
  output logic                      begin_l,
  output logic                      begin_ip,
  input  logic                      done_l,
  input  logic                      done_ip,
  output logic                      busy,
  output logic                      err_dim,
  output logic                      err_timeout,
  input  logic                      err_clr,
  output logic [CNT_W-1:0]          op_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [DIM_W-1:0] DIM_MIN  = DIM_W'(2);
  localparam logic [DIM_W-1:0] DIM_MAX  = DIM_W'(MAX_DIM);

  state_t                    state_q;
  logic                      kind_q;
  logic [MAX_DIM*DATA_W-1:0] a_q, b_q;
  logic                      beginL_q, beginIp_q;
  logic                      errDim_q, errTimeout_q;
  logic [TMR_W-1:0]          timer_q;
  logic [CNT_W-1:0]          count_q;

  logic [MAX_DIM*DATA_W-1:0] aMasked, bMasked;
  logic [DIM_W-1:0]          bDim;
  logic                      dimLegal;
  logic                      doneSel;

  // A length operation has no B operand, so its mask selects no lanes at all.
  assign bDim     = (cmd.op_kind == OP_IP) ? cmd.op_dim : '0;
  assign dimLegal = (cmd.op_dim >= DIM_MIN) && (cmd.op_dim <= DIM_MAX);
  assign doneSel  = (kind_q == OP_IP) ? done_ip : done_l;

  vec_lane_mask #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) u_maskA (
    .dim_i  (cmd.op_dim),
    .data_i (cmd.a_in),
    .data_o (aMasked)
  );

  vec_lane_mask #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) u_maskB (
    .dim_i  (bDim),
    .data_i (cmd.b_in),
    .data_o (bMasked)
  );

  // Error sets are written after the clear so a coincident new error survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      kind_q       <= OP_LEN;
      a_q          <= '0;
      b_q          <= '0;
      beginL_q     <= 1'b0;
      beginIp_q    <= 1'b0;
      errDim_q     <= 1'b0;
      errTimeout_q <= 1'b0;
      timer_q      <= '0;
      count_q      <= '0;
    end else begin
      beginL_q  <= 1'b0;
      beginIp_q <= 1'b0;
      if (err_clr) begin
        errDim_q     <= 1'b0;
        errTimeout_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (cmd.op_valid) begin
            if (dimLegal) begin
              a_q       <= aMasked;
              b_q       <= bMasked;
              kind_q    <= cmd.op_kind;
              beginL_q  <= (cmd.op_kind == OP_LEN);
              beginIp_q <= (cmd.op_kind == OP_IP);
              state_q   <= ISSUE;
            end else begin
              errDim_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (doneSel) begin
            count_q <= count_q + CNT_W'(1);
            state_q <= IDLE;
          end else if (timer_q == TMR_LAST) begin
            errTimeout_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd.op_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign a_out        = a_q;
  assign b_out        = b_q;
  assign begin_l      = beginL_q;
  assign begin_ip     = beginIp_q;
  assign err_dim      = errDim_q;
  assign err_timeout  = errTimeout_q;
  assign op_count     = count_q;

endmodule

// File: tb/tb_vec_op_dispatch.sv
// Scoreboard bench for vec_op_dispatch: issued operations queue their expected
// operands, and a monitor checks them whenever a begin strobe appears.
module tb_vec_op_dispatch;

  localparam int DATA_W  = 32;
  localparam int MAX_DIM = 4;
  localparam int DIM_W   = 3;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 2;
  localparam int BUS_W   = MAX_DIM * DATA_W;

  typedef struct {
    logic             kind;
    logic [BUS_W-1:0] a;
    logic [BUS_W-1:0] b;
  } expOp_t;

  logic             clock;
  logic             reset_n;
  logic [BUS_W-1:0] a_out, b_out;
  logic             begin_l, begin_ip;
  logic             done_l, done_ip;
  logic             busy, err_dim, err_timeout, err_clr;
  logic [CNT_W-1:0] op_count;

  int               testsRun;
  int               testsFailed;
  expOp_t           expQ[$];
  expOp_t           monExp;
  logic             prevBegin;
  logic [CNT_W-1:0] expCount;

  vec_op_dispatch_if #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) cmd ();

  vec_op_dispatch #(
    .DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd         (cmd),
    .a_out       (a_out),
    .b_out       (b_out),
    .begin_l     (begin_l),
    .begin_ip    (begin_ip),
    .done_l      (done_l),
    .done_ip     (done_ip),
    .busy        (busy),
    .err_dim     (err_dim),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .op_count    (op_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [BUS_W-1:0] lanes(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic checkBus(input string name, input logic [BUS_W-1:0] actual,
                          input logic [BUS_W-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic expBusy,
                             input logic expErrDim, input logic expErrTimeout);
    checkBit({name, "_ready"}, cmd.op_ready, ~expBusy);
    checkBit({name, "_busy"}, busy, expBusy);
    checkBit({name, "_err_dim"}, err_dim, expErrDim);
    checkBit({name, "_err_timeout"}, err_timeout, expErrTimeout);
    checkBus({name, "_op_count"}, BUS_W'(op_count), BUS_W'(expCount));
  endtask

  task automatic waitReady();
    int n = 0;
    while (cmd.op_ready !== 1'b1 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkBit("ready_wait", cmd.op_ready, 1'b1);
  endtask

  // Drives one handshake; returns one step after the accepting edge.
  task automatic applyStimulus(input logic kind, input logic [DIM_W-1:0] dim,
                               input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b,
                               input logic [BUS_W-1:0] expA, input logic [BUS_W-1:0] expB,
                               input bit legal);
    expOp_t e;
    waitReady();
    cmd.op_valid = 1'b1;
    cmd.op_kind  = kind;
    cmd.op_dim   = dim;
    cmd.a_in     = a;
    cmd.b_in     = b;
    if (legal) begin
      e.kind = kind;
      e.a    = expA;
      e.b    = expB;
      expQ.push_back(e);
    end
    @(posedge clock);
    #1;
    cmd.op_valid = 1'b0;
    cmd.a_in     = '1;
    cmd.b_in     = '1;
  endtask

  task automatic pulseDone(input logic sel, input int delay);
    repeat (delay) @(posedge clock);
    #1;
    if (sel) done_ip = 1'b1;
    else     done_l  = 1'b1;
    @(posedge clock);
    #1;
    done_l  = 1'b0;
    done_ip = 1'b0;
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
  endtask

  // Monitor: every begin strobe must match the oldest queued operation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && (begin_l === 1'b1 || begin_ip === 1'b1)) begin
      checkBit("begin_single_cycle", prevBegin, 1'b0);
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_begin: got begin_l=%0b begin_ip=%0b expected none",
                 begin_l, begin_ip);
      end else begin
        monExp = expQ.pop_front();
        checkBit("begin_l", begin_l, ~monExp.kind);
        checkBit("begin_ip", begin_ip, monExp.kind);
        checkBus("a_out", a_out, monExp.a);
        checkBus("b_out", b_out, monExp.b);
      end
    end
    prevBegin = begin_l | begin_ip;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    testsFailed++;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    prevBegin    = 1'b0;
    expCount     = '0;
    reset_n      = 1'b0;
    cmd.op_valid = 1'b0;
    cmd.op_kind  = 1'b0;
    cmd.op_dim   = '0;
    cmd.a_in     = '0;
    cmd.b_in     = '0;
    done_l       = 1'b0;
    done_ip      = 1'b0;
    err_clr      = 1'b0;

    // Reset state
    #12;
    checkBus("reset_a_out", a_out, '0);
    checkBus("reset_b_out", b_out, '0);
    checkBit("reset_begin_l", begin_l, 1'b0);
    checkBit("reset_begin_ip", begin_ip, 1'b0);
    checkOutput("reset", 1'b0, 1'b0, 1'b0);
    #6 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Length op, dim 2: upper lanes and all of B are zeroed
    applyStimulus(1'b0, 3'd2, lanes(1, 2, 7, 9), lanes(5, 5, 5, 5),
                  lanes(1, 2, 0, 0), '0, 1'b1);
    checkOutput("len_issue", 1'b1, 1'b0, 1'b0);
    pulseDone(1'b0, 2);
    expCount = expCount + 2'd1;
    checkOutput("len_done", 1'b0, 1'b0, 1'b0);

    // Inner product, dim 4, with an early done_ip during ISSUE
    applyStimulus(1'b1, 3'd4, lanes(3, 4, 5, 6), lanes(1, 1, 1, 1),
                  lanes(3, 4, 5, 6), lanes(1, 1, 1, 1), 1'b1);
    pulseDone(1'b1, 0);
    checkOutput("ip_early_done", 1'b1, 1'b0, 1'b0);
    pulseDone(1'b1, 1);
    expCount = expCount + 2'd1;
    checkOutput("ip_done", 1'b0, 1'b0, 1'b0);
    checkBus("ip_hold_a", a_out, lanes(3, 4, 5, 6));
    checkBus("ip_hold_b", b_out, lanes(1, 1, 1, 1));

    // Illegal dimensions are consumed without effect except err_dim
    applyStimulus(1'b0, 3'd1, lanes(11, 12, 13, 14), '0, '0, '0, 1'b0);
    checkOutput("dim1", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd5, lanes(11, 12, 13, 14), lanes(2, 2, 2, 2), '0, '0, 1'b0);
    checkOutput("dim5", 1'b0, 1'b1, 1'b0);
    checkBus("dim5_hold_a", a_out, lanes(3, 4, 5, 6));
    pulseClear();
    checkOutput("dim_clear", 1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    applyStimulus(1'b0, 3'd0, lanes(1, 1, 1, 1), '0, '0, '0, 1'b0);
    err_clr = 1'b0;
    checkOutput("dim0_set_beats_clear", 1'b0, 1'b1, 1'b0);
    pulseClear();

    // Timeout after 8 WAIT cycles
    applyStimulus(1'b0, 3'd3, lanes(10, 20, 30, 40), lanes(7, 7, 7, 7),
                  lanes(10, 20, 30, 0), '0, 1'b1);
    repeat (8) @(posedge clock);
    #1;
    checkOutput("timeout_last_wait", 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("timeout_abort", 1'b0, 1'b0, 1'b1);
    pulseClear();
    checkOutput("timeout_clear", 1'b0, 1'b0, 1'b0);

    // Done on the final WAIT cycle wins over the timeout
    applyStimulus(1'b0, 3'd3, lanes(10, 20, 30, 40), lanes(7, 7, 7, 7),
                  lanes(10, 20, 30, 0), '0, 1'b1);
    pulseDone(1'b0, 8);
    expCount = expCount + 2'd1;
    checkOutput("done_at_timeout", 1'b0, 1'b0, 1'b0);

    // Wrong-unit done is ignored in WAIT; count wraps to 0 here
    applyStimulus(1'b0, 3'd2, lanes(5, 6, 7, 8), lanes(3, 3, 3, 3),
                  lanes(5, 6, 0, 0), '0, 1'b1);
    pulseDone(1'b1, 1);
    checkOutput("wrong_done", 1'b1, 1'b0, 1'b0);
    pulseDone(1'b0, 1);
    expCount = expCount + 2'd1;
    checkOutput("right_done", 1'b0, 1'b0, 1'b0);
    checkBus("wrap_count", BUS_W'(op_count), '0);

    // Asynchronous reset in the middle of WAIT
    applyStimulus(1'b1, 3'd2, lanes(1, 2, 3, 4), lanes(9, 9, 9, 9),
                  lanes(1, 2, 0, 0), lanes(9, 9, 0, 0), 1'b1);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    expCount = '0;
    checkBus("rst_a_out", a_out, '0);
    checkBus("rst_b_out", b_out, '0);
    checkBit("rst_begin_l", begin_l, 1'b0);
    checkBit("rst_begin_ip", begin_ip, 1'b0);
    checkOutput("rst_mid_wait", 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    pulseDone(1'b0, 0);
    checkOutput("rst_stale_done", 1'b0, 1'b0, 1'b0);

    // Five completions with a 2-bit counter leave it at 1
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 3'd3, lanes(k, k + 1, k + 2, k + 3), lanes(2, 2, 2, 2),
                    lanes(k, k + 1, k + 2, 0), lanes(2, 2, 2, 0), 1'b1);
      pulseDone(1'b1, 1);
      expCount = expCount + 2'd1;
      checkOutput("loop_done", 1'b0, 1'b0, 1'b0);
    end
    checkBus("final_count", BUS_W'(op_count), BUS_W'(2'd1));

    repeat (2) @(posedge clock);
    checkBus("queue_drained", BUS_W'(expQ.size()), '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
